// File: rtl/uart_bist_engine.sv
// rtl/uart_bist_engine.sv - LFSR-driven UART loopback self-test with MISR signature compare
// Optional feature macro: UART_BIST_PARITY_EN (even parity bit after the data bits)
module uart_bist_engine #(
    parameter int                DATA_BITS  = 8,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
    parameter int                NUM_FRAMES = 32,
    parameter int                SIG_W      = 16,
    parameter logic [SIG_W-1:0]  SIG_POLY   = 16'h1021,
    parameter int                TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic [SIG_W-1:0] expected_sig,
    input  logic             rx_in,
    output logic             tx_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [7:0]       err_cnt,
    output logic [SIG_W-1:0] signature,
    output logic [15:0]      frame_cnt
);

`ifdef UART_BIST_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_LEN = DATA_BITS + 3 + PAR_BITS;
    localparam int POS_W     = $clog2(FRAME_LEN);
    localparam int TO_W      = $clog2(TIMEOUT + 1);

    localparam logic [POS_W-1:0]     POS_LAST_DATA = POS_W'(DATA_BITS);
`ifdef UART_BIST_PARITY_EN
    localparam logic [POS_W-1:0]     POS_PARITY    = POS_W'(DATA_BITS + 1);
`endif
    localparam logic [POS_W-1:0]     POS_STOP      = POS_W'(DATA_BITS + 1 + PAR_BITS);
    localparam logic [POS_W-1:0]     POS_IDLE      = POS_W'(DATA_BITS + 2 + PAR_BITS);
    localparam logic [15:0]          NF            = 16'(NUM_FRAMES);
    localparam logic [TO_W-1:0]      TO_LAST       = TO_W'(TIMEOUT - 1);
    localparam logic [LFSR_W-1:0]    SEED_EFF      = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam logic [DATA_BITS-1:0] RX_MSB        = DATA_BITS'(1) << (DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_SEED, S_RUN, S_COMPARE, S_DONE} state_t;
    state_t state, state_next;

    logic [LFSR_W-1:0]    lfsr;
    logic [LFSR_W-1:0]    lfsr_next;
    logic [DATA_BITS-1:0] tx_shift;
    logic [POS_W-1:0]     tx_pos;
    logic [15:0]          tx_frames;
    logic                 rx_active;
    logic [POS_W-1:0]     rx_pos;
    logic [DATA_BITS-1:0] rx_shift;
    logic [TO_W-1:0]      to_cnt;
    logic [1:0]           err_inc;
    logic [8:0]           err_sum;
    logic [SIG_W-1:0]     sig_next;
`ifdef UART_BIST_PARITY_EN
    logic                 tx_par;
    logic                 par_err;
`endif

    assign lfsr_next = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    assign sig_next  = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? SIG_POLY : '0)
                     ^ SIG_W'(rx_shift);

    // A frame can carry both a stop error and a parity error, so the increment is up to 2.
    always_comb begin
        err_inc = {1'b0, ~rx_in};
`ifdef UART_BIST_PARITY_EN
        err_inc = err_inc + {1'b0, par_err};
`endif
        err_sum = {1'b0, err_cnt} + {7'd0, err_inc};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE:    if (start) state_next = S_SEED;
            S_SEED: begin
                busy       = 1'b1;
                state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (frame_cnt == NF || timeout) state_next = S_COMPARE;
            end
            S_COMPARE: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_next = S_SEED;
            end
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_out    <= 1'b1;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            err_cnt   <= 8'd0;
            signature <= '0;
            frame_cnt <= 16'd0;
            lfsr      <= '0;
            tx_shift  <= '0;
            tx_pos    <= '0;
            tx_frames <= 16'd0;
            rx_active <= 1'b0;
            rx_pos    <= '0;
            rx_shift  <= '0;
            to_cnt    <= '0;
`ifdef UART_BIST_PARITY_EN
            tx_par    <= 1'b0;
            par_err   <= 1'b0;
`endif
        end else begin
            case (state)
                S_SEED: begin
                    tx_out    <= 1'b1;
                    pass      <= 1'b0;
                    timeout   <= 1'b0;
                    err_cnt   <= 8'd0;
                    signature <= '0;
                    frame_cnt <= 16'd0;
                    lfsr      <= SEED_EFF;
                    tx_pos    <= '0;
                    tx_frames <= 16'd0;
                    rx_active <= 1'b0;
                    rx_pos    <= '0;
                    to_cnt    <= '0;
`ifdef UART_BIST_PARITY_EN
                    par_err   <= 1'b0;
`endif
                end
                S_RUN: if (tick) begin
                    // Transmit: start, data LSB first, [parity], stop, one idle bit.
                    if (tx_frames != NF) begin
                        if (tx_pos == '0) begin
                            tx_out   <= 1'b0;
                            tx_shift <= lfsr[DATA_BITS-1:0];
`ifdef UART_BIST_PARITY_EN
                            tx_par   <= ^lfsr[DATA_BITS-1:0];
`endif
                        end else if (tx_pos <= POS_LAST_DATA) begin
                            tx_out   <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
`ifdef UART_BIST_PARITY_EN
                        else if (tx_pos == POS_PARITY) begin
                            tx_out <= tx_par;
                        end
`endif
                        else if (tx_pos == POS_STOP) begin
                            tx_out <= 1'b1;
                            lfsr   <= lfsr_next;
                        end else begin
                            tx_out <= 1'b1;
                        end
                        if (tx_pos == POS_IDLE) begin
                            tx_pos    <= '0;
                            tx_frames <= tx_frames + 16'd1;
                        end else begin
                            tx_pos <= tx_pos + 1'b1;
                        end
                    end else begin
                        tx_out <= 1'b1;
                    end

                    // Receive and compact; the idle-time counter only runs while frames remain.
                    if (!rx_active) begin
                        if (frame_cnt != NF) begin
                            if (!rx_in) begin
                                rx_active <= 1'b1;
                                rx_pos    <= POS_W'(1);
                                to_cnt    <= '0;
                            end else begin
                                if (to_cnt == TO_LAST) timeout <= 1'b1;
                                to_cnt <= to_cnt + 1'b1;
                            end
                        end
                    end else if (rx_pos <= POS_LAST_DATA) begin
                        rx_shift <= (rx_shift >> 1) | (rx_in ? RX_MSB : '0);
                        rx_pos   <= rx_pos + 1'b1;
                    end
`ifdef UART_BIST_PARITY_EN
                    else if (rx_pos == POS_PARITY) begin
                        par_err <= rx_in ^ (^rx_shift);
                        rx_pos  <= rx_pos + 1'b1;
                    end
`endif
                    else begin
                        err_cnt   <= err_sum[8] ? 8'hFF : err_sum[7:0];
                        signature <= sig_next;
                        frame_cnt <= frame_cnt + 16'd1;
                        rx_active <= 1'b0;
`ifdef UART_BIST_PARITY_EN
                        par_err   <= 1'b0;
`endif
                    end
                end
                S_COMPARE: pass <= (signature == expected_sig) && (err_cnt == 8'd0) && !timeout;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bist_engine.sv
// tb/tb_uart_bist_engine.sv - table-driven and randomized bench for uart_bist_engine
module tb_uart_bist_engine;
    localparam int DATA_BITS  = 8;
    localparam int NUM_FRAMES = 32;
    localparam int TIMEOUT    = 64;
`ifdef UART_BIST_PARITY_EN
    localparam int FRAME_TICKS = DATA_BITS + 4;
`else
    localparam int FRAME_TICKS = DATA_BITS + 3;
`endif
    localparam int BUDGET = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, tick, start, start1, rx_high, force0;
    logic [15:0] expected_sig, expected_sig1;
    logic        rx_in, tx_out, busy, done, pass, timeout;
    logic [7:0]  err_cnt;
    logic [15:0] signature, frame_cnt;
    logic        rx1, tx1, busy1, done1, pass1, timeout1;
    logic [7:0]  err1;
    logic [15:0] sig1, fc1;

    assign rx_in = rx_high ? 1'b1 : (tx_out & ~force0);
    assign rx1   = tx1;

    uart_bist_engine dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .expected_sig(expected_sig),
        .rx_in(rx_in), .tx_out(tx_out), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .err_cnt(err_cnt), .signature(signature), .frame_cnt(frame_cnt)
    );

    uart_bist_engine #(.NUM_FRAMES(1), .SEED(16'h0000)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .start(start1), .expected_sig(expected_sig1),
        .rx_in(rx1), .tx_out(tx1), .busy(busy1), .done(done1), .pass(pass1),
        .timeout(timeout1), .err_cnt(err1), .signature(sig1), .frame_cnt(fc1)
    );

    typedef struct {
        string       name;
        bit          tied_high;
        int          err_frame;
        logic [15:0] sig_xor;
        bit          rand_tick;
        int          glitch_tick;
        bit          exp_pass;
        int          exp_err;
        int          exp_frames;
        bit          exp_timeout;
    } vec_t;

    int passed = 0;
    int total  = 0;

    int          r_total_ticks, r_run_ticks;
    logic [7:0]  r_first;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Whole-run outcome from the frame-level rules: word f is the low byte of the
    // pattern register after f steps, and every received word folds into the signature.
    function automatic void model_run(input int nf, input logic [15:0] seed,
                                      output logic [15:0] sig, output logic [7:0] first);
        logic [15:0] lfsr;
        logic [7:0]  data;
        int          fb;
        lfsr  = (seed == 16'h0) ? 16'd1 : seed;
        sig   = 16'h0;
        first = lfsr[7:0];
        for (int f = 0; f < nf; f++) begin
            data = lfsr[7:0];
            sig  = (sig << 1) ^ (sig[15] ? 16'h1021 : 16'h0) ^ {8'h00, data};
            fb   = $countones(lfsr & 16'hB400) % 2;
            lfsr = (lfsr << 1) | 16'(fb);
        end
    endfunction

    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [44:0] outs();
        return {tx_out, busy, done, pass, timeout, err_cnt, signature, frame_cnt};
    endfunction

    task automatic run_test(input bit tied_high, input int err_frame, input logic [15:0] esig,
                            input bit rand_tick, input int glitch_tick, input int reset_tick);
        int   cycle_idx;
        int   run_ticks;
        int   total_ticks;
        bit   glitched;
        logic t;
        logic [7:0] first;
        rx_high      = tied_high;
        force0       = 1'b0;
        expected_sig = esig;
        start = 1'b1;
        cyc(1'b1);
        start       = 1'b0;
        total_ticks = 1;
        run_ticks   = 0;
        cycle_idx   = 0;
        glitched    = 1'b0;
        first       = 8'h00;
        while (done !== 1'b1 && cycle_idx < BUDGET) begin
            cycle_idx++;
            if (rand_tick) t = ($urandom_range(0, 2) == 0);
            else           t = ((cycle_idx % 4) == 0);
            if (glitch_tick > 0 && run_ticks == glitch_tick && !glitched) begin
                start    = 1'b1;
                glitched = 1'b1;
            end
            cyc(t);
            start = 1'b0;
            if (t) begin
                total_ticks++;
                if (cycle_idx >= 2) begin
                    run_ticks++;
                    if (run_ticks >= 2 && run_ticks <= DATA_BITS + 1) first[run_ticks-2] = tx_out;
                    force0 = (err_frame >= 0 && run_ticks == err_frame * FRAME_TICKS + FRAME_TICKS - 1);
                    if (reset_tick >= 0 && run_ticks == reset_tick) begin
                        rst = 1'b0;
                        #1;
                        check("reset_async_mid_run", outs(), {1'b1, 44'd0});
                        cyc(1'b1);
                        cyc(1'b0);
                        check("reset_held_mid_run", outs(), {1'b1, 44'd0});
                        rst    = 1'b1;
                        force0 = 1'b0;
                        cyc(1'b0);
                        return;
                    end
                end
            end
        end
        force0        = 1'b0;
        r_total_ticks = total_ticks;
        r_run_ticks   = run_ticks;
        r_first       = first;
        check("done_within_budget", done, 1'b1);
    endtask

    initial begin
        vec_t        vecs[7];
        logic [15:0] m_sig, m1_sig, exp_sig_v;
        logic [7:0]  m_first, m1_first, first1;
        int          cycle_idx, run_ticks;

        rst = 1'b0; tick = 1'b0; start = 1'b0; start1 = 1'b0;
        rx_high = 1'b0; force0 = 1'b0; expected_sig = 16'h0; expected_sig1 = 16'h0;

        model_run(NUM_FRAMES, 16'hACE1, m_sig, m_first);
        model_run(1, 16'h0000, m1_sig, m1_first);

        vecs[0] = '{"golden",      1'b0, -1, 16'h0000, 1'b0, 0,  1'b1, 0, NUM_FRAMES, 1'b0};
        vecs[1] = '{"bad_sig",     1'b0, -1, 16'h0001, 1'b0, 0,  1'b0, 0, NUM_FRAMES, 1'b0};
        vecs[2] = '{"timeout",     1'b1, -1, 16'h0000, 1'b0, 0,  1'b0, 0, 0,          1'b1};
        vecs[3] = '{"stop5",       1'b0,  5, 16'h0000, 1'b0, 0,  1'b0, 1, NUM_FRAMES, 1'b0};
        vecs[4] = '{"rand_tick",   1'b0, -1, 16'h0000, 1'b1, 0,  1'b1, 0, NUM_FRAMES, 1'b0};
        vecs[5] = '{"rand_err",    1'b0, int'($urandom_range(0, NUM_FRAMES - 1)),
                    16'(($urandom_range(1, 65535))), 1'b1, 0, 1'b0, 1, NUM_FRAMES, 1'b0};
        vecs[6] = '{"start_in_run", 1'b0, -1, 16'h0000, 1'b0, 50, 1'b1, 0, NUM_FRAMES, 1'b0};

        repeat (3) cyc(1'b0);
        check("reset_state", outs(), {1'b1, 44'd0});
        check("reset_state_dut1", {tx1, busy1, done1, pass1, timeout1, err1, sig1, fc1}, {1'b1, 44'd0});
        rst = 1'b1;
        cyc(1'b0);

        for (int i = 0; i < 7; i++) begin
            exp_sig_v = vecs[i].tied_high ? 16'h0 : m_sig;
            run_test(vecs[i].tied_high, vecs[i].err_frame, exp_sig_v ^ vecs[i].sig_xor,
                     vecs[i].rand_tick, vecs[i].glitch_tick, -1);
            check({vecs[i].name, "_done"},      done,      1'b1);
            check({vecs[i].name, "_busy"},      busy,      1'b0);
            check({vecs[i].name, "_pass"},      pass,      vecs[i].exp_pass);
            check({vecs[i].name, "_err_cnt"},   err_cnt,   8'(vecs[i].exp_err));
            check({vecs[i].name, "_frame_cnt"}, frame_cnt, 16'(vecs[i].exp_frames));
            check({vecs[i].name, "_timeout"},   timeout,   vecs[i].exp_timeout);
            check({vecs[i].name, "_signature"}, signature, exp_sig_v);
            if (!vecs[i].rand_tick) begin
                if (vecs[i].tied_high) begin
                    check({vecs[i].name, "_run_ticks"}, r_run_ticks, TIMEOUT);
                end else begin
                    check({vecs[i].name, "_ticks_start_to_done"}, r_total_ticks,
                          NUM_FRAMES * FRAME_TICKS + 1);
                    check({vecs[i].name, "_first_byte"}, r_first, m_first);
                end
            end
        end

        // Reset in the middle of frame 10, then a clean rerun from IDLE.
        run_test(1'b0, -1, m_sig, 1'b0, 0, 10 * FRAME_TICKS + 4);
        run_test(1'b0, -1, m_sig, 1'b0, 0, -1);
        check("rerun_pass",      pass,      1'b1);
        check("rerun_signature", signature, m_sig);
        check("rerun_frames",    frame_cnt, 16'(NUM_FRAMES));

        // DONE holds its results while ticks keep arriving.
        for (int k = 0; k < 20; k++) cyc(k[0]);
        check("done_hold", {done, pass, signature}, {1'b1, 1'b1, m_sig});

        // Single-frame instance with an all-zero seed.
        expected_sig1 = m1_sig;
        start1 = 1'b1;
        cyc(1'b1);
        start1    = 1'b0;
        cycle_idx = 0;
        run_ticks = 0;
        first1    = 8'h00;
        while (done1 !== 1'b1 && cycle_idx < BUDGET) begin
            cycle_idx++;
            cyc((cycle_idx % 4) == 0);
            if ((cycle_idx % 4) == 0 && cycle_idx >= 2) begin
                run_ticks++;
                if (run_ticks >= 2 && run_ticks <= DATA_BITS + 1) first1[run_ticks-2] = tx1;
            end
        end
        check("nf1_done",       done1, 1'b1);
        check("nf1_pass",       pass1, 1'b1);
        check("nf1_signature",  sig1,  m1_sig);
        check("nf1_frame_cnt",  fc1,   16'd1);
        check("nf1_err_cnt",    err1,  8'd0);
        check("nf1_first_byte", first1, m1_first);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
